i2s_rx_frontend: RTL and testbench
==================================

# i2s_rx_frontend

Serial audio receiver that feeds the chorus/karaoke effect chain. It takes an external I2S stream (bit clock, word select and serial data) into the FPGA system-clock domain. It deserialises the left and right words and delivers one 16-bit mono sample per stereo frame, with a single-cycle valid strobe. Framing faults are flagged without ever emitting a corrupt sample.

## Interface
- DATA_WIDTH, 16: bits captured per channel word, MSB first; also the width of all sample outputs.
- SLOT_WIDTH, 32: maximum BCLK periods per channel slot; must be ≥ DATA_WIDTH.
- MONO_SEL, 2: mono source for audio_out. 0 = left, 1 = right, 2 = signed average of left and right.

- clk  in  1  system clock (50 MHz); the only clock.
- rst  in  1  asynchronous, active-high reset.
- i2s_bclk  in  1  external bit clock; asynchronous to clk; frequency ≤ clk/4.
- i2s_lrck  in  1  word select; 0 = left slot, 1 = right slot.
- i2s_sdata  in  1  serial data, two's complement, MSB first.
- enable  in  1  high = receive; low = abort and resynchronise.
- err_clr  in  1  one-cycle pulse; clears frame_err.
- audio_out  out  DATA_WIDTH  mono sample selected by MONO_SEL.
- audio_left  out  DATA_WIDTH  last complete left word.
- audio_right  out  DATA_WIDTH  last complete right word.
- sample_valid  out  1  one-cycle pulse; all three sample outputs updated this cycle.
- frame_err  out  1  sticky framing-error flag.

## Operation
- **Synchronisers.** i2s_bclk, i2s_lrck and i2s_sdata each pass through 2 flops; bclk has a third flop for edge detection. A BCLK rising event is sync2 = 1 and sync3 = 0. All capture logic acts only on rising events. lrck and sdata are taken from their sync2 flops, which keeps them aligned with bclk.
- **Slot boundary.** A slot boundary is a rising event where the sampled lrck differs from lrck_q, the lrck value held from the previous event.
  - The data bit sampled at the boundary event belongs to the previous slot and is discarded (I2S one-bit delay).
  - The new slot's channel is the new lrck value.
  - bit_cnt is cleared to 0 at the boundary.
- **FSM states.**
  - WAIT_SYNC (reset state): ignore data. A boundary with new lrck = 0 goes to SHIFT with channel = left. A 0→1 boundary stays in WAIT_SYNC.
  - SHIFT: on each non-boundary rising event, shift sdata into shreg from the LSB side and increment bit_cnt. When bit_cnt reaches DATA_WIDTH:
    - Left channel: latch shreg into left_hold and set left_ok.
    - Right channel: latch into right_hold; if left_ok is set, raise frame_done and clear left_ok.
    - Go to PAD.
  - PAD: ignore data bits; increment bit_cnt per rising event. A boundary goes to SHIFT with the new channel.
- **Errors.**
  - A boundary while in SHIFT means a short word: discard shreg, clear left_ok, set frame_err, and go to SHIFT for the new channel.
  - bit_cnt exceeding SLOT_WIDTH with no boundary sets frame_err and goes to WAIT_SYNC.
- **Output on frame_done.**
  - audio_left ← left_hold and audio_right ← right_hold.
  - audio_out ← selected source. Average = 17-bit sign-extended sum, arithmetic shift right 1, low DATA_WIDTH bits (no overflow possible).
  - sample_valid pulses.
- A right word completed without left_ok set produces no output (no orphan samples).
- **enable low:** state goes to WAIT_SYNC and left_ok is cleared. The synchronisers keep running. Sample outputs hold their values; sample_valid stays 0. frame_err is unaffected.
- **frame_err:** err_clr clears it. If a new error and err_clr occur in the same cycle, set wins.
- **Reset values:** every output is 0, state = WAIT_SYNC, bit_cnt = 0, lrck_q = 0, left_ok = 0, all synchroniser flops 0.

## Timing
- Input-to-action latency: number the first clk edge that samples i2s_bclk high as edge 1. The shift or latch for that BCLK edge occurs at edge 3.
- sample_valid and the updated sample outputs are registered at edge 4, counted from the bclk rising edge that carries the right word's DATA_WIDTH-th bit.
- sample_valid is exactly 1 clk wide, at most once per stereo frame.
- Sample outputs are stable between pulses.
- Asynchronous reset mid-word: all state clears immediately. The first sample afterwards requires a full new left+right frame that begins after a 1→0 lrck boundary.

## Test plan
- Reset, then 32-bit-slot frames with L = 0x1234, R = 0xABCD and MONO_SEL = 0 -> one sample_valid pulse per frame; audio_left = 0x1234, audio_right = 0xABCD, audio_out = 0x1234; latency of exactly 4 edges from the right bit-16 BCLK rise.
- MONO_SEL = 2, L = 0x7FFF, R = 0x7FFF -> audio_out = 0x7FFF. With L = 0x8000, R = 0xFFFF -> audio_out = 0xBFFF. With L = 0x0001, R = 0xFFFE -> audio_out = 0xFFFF.
- Stream starts mid-right-slot -> no valid until the first complete left+right frame; no frame_err.
- Left slot cut to 10 bits by an early lrck toggle -> frame_err = 1, no valid for that frame. The next good frame gives valid and frame_err stays set. An err_clr pulse -> 0.
- lrck held static for 40 BCLK periods -> frame_err = 1 and state resyncs; data resumes correctly after the next 1→0 lrck boundary.
- Deassert enable mid-right-word, reassert -> no valid for the interrupted frame, outputs hold their previous values; normal output resumes on the next full frame. Asserting rst mid-word -> all outputs 0 at once.

Source files
------------

// File: rtl/i2s_rx_frontend.sv
// I2S receiver front end: synchronises an external bit clock, deserialises left/right
// words and emits one mono sample per stereo frame with a single-cycle strobe.
module i2s_rx_frontend #(
    parameter int DATA_WIDTH = 16,
    parameter int SLOT_WIDTH = 32,
    parameter int MONO_SEL   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i2s_bclk,
    input  logic                  i2s_lrck,
    input  logic                  i2s_sdata,
    input  logic                  enable,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] audio_out,
    output logic [DATA_WIDTH-1:0] audio_left,
    output logic [DATA_WIDTH-1:0] audio_right,
    output logic                  sample_valid,
    output logic                  frame_err
);
    localparam int CW = $clog2(SLOT_WIDTH + 2);

    typedef enum logic [1:0] {WAIT_SYNC, SHIFT, PAD} state_t;

    state_t                state, state_nx;
    logic [2:0]            bclk_sync;
    logic [1:0]            lrck_sync, sdata_sync;
    logic                  rise, lrck_s, sdata_s, boundary;
    logic                  lrck_q;
    logic [CW-1:0]         bit_cnt, bit_cnt_nx, bit_cnt_inc;
    logic                  chan, chan_nx;
    logic [DATA_WIDTH-1:0] shreg, shreg_nx, left_hold, lh_nx, right_hold, rh_nx;
    logic                  left_ok, left_ok_nx;
    logic                  frame_done, frame_done_nx;
    logic                  err_set;
    logic [DATA_WIDTH:0]   avg_sum;
    logic [DATA_WIDTH-1:0] mono;

    assign rise        = bclk_sync[1] & ~bclk_sync[2];
    assign lrck_s      = lrck_sync[1];
    assign sdata_s     = sdata_sync[1];
    assign boundary    = rise && (lrck_s != lrck_q);
    assign bit_cnt_inc = bit_cnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bclk_sync  <= '0;
            lrck_sync  <= '0;
            sdata_sync <= '0;
            lrck_q     <= 1'b0;
        end else begin
            bclk_sync  <= {bclk_sync[1:0], i2s_bclk};
            lrck_sync  <= {lrck_sync[0], i2s_lrck};
            sdata_sync <= {sdata_sync[0], i2s_sdata};
            if (rise)
                lrck_q <= lrck_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= WAIT_SYNC;
            bit_cnt    <= '0;
            chan       <= 1'b0;
            shreg      <= '0;
            left_hold  <= '0;
            right_hold <= '0;
            left_ok    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            bit_cnt    <= bit_cnt_nx;
            chan       <= chan_nx;
            shreg      <= shreg_nx;
            left_hold  <= lh_nx;
            right_hold <= rh_nx;
            left_ok    <= left_ok_nx;
            frame_done <= frame_done_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        bit_cnt_nx    = bit_cnt;
        chan_nx       = chan;
        shreg_nx      = shreg;
        lh_nx         = left_hold;
        rh_nx         = right_hold;
        left_ok_nx    = left_ok;
        frame_done_nx = 1'b0;
        err_set       = 1'b0;
        if (!enable) begin
            state_nx   = WAIT_SYNC;
            left_ok_nx = 1'b0;
            bit_cnt_nx = '0;
        end else if (rise) begin
            case (state)
                WAIT_SYNC: begin
                    // Only a right-to-left transition marks a frame start.
                    if (boundary && !lrck_s) begin
                        state_nx   = SHIFT;
                        chan_nx    = 1'b0;
                        bit_cnt_nx = '0;
                    end
                end
                SHIFT: begin
                    if (boundary) begin
                        err_set    = 1'b1;
                        left_ok_nx = 1'b0;
                        shreg_nx   = '0;
                        chan_nx    = lrck_s;
                        bit_cnt_nx = '0;
                    end else begin
                        shreg_nx   = {shreg[DATA_WIDTH-2:0], sdata_s};
                        bit_cnt_nx = bit_cnt_inc;
                        if (bit_cnt_inc == CW'(DATA_WIDTH)) begin
                            state_nx = PAD;
                            if (chan) begin
                                rh_nx = shreg_nx;
                                if (left_ok) begin
                                    frame_done_nx = 1'b1;
                                    left_ok_nx    = 1'b0;
                                end
                            end else begin
                                lh_nx      = shreg_nx;
                                left_ok_nx = 1'b1;
                            end
                        end
                    end
                end
                PAD: begin
                    if (boundary) begin
                        state_nx   = SHIFT;
                        chan_nx    = lrck_s;
                        bit_cnt_nx = '0;
                    end else if (bit_cnt_inc > CW'(SLOT_WIDTH)) begin
                        err_set    = 1'b1;
                        state_nx   = WAIT_SYNC;
                        left_ok_nx = 1'b0;
                        bit_cnt_nx = '0;
                    end else begin
                        bit_cnt_nx = bit_cnt_inc;
                    end
                end
                default: state_nx = WAIT_SYNC;
            endcase
        end
    end

    // Sign-extended sum cannot overflow; the shift keeps the floor of the average.
    assign avg_sum = {left_hold[DATA_WIDTH-1], left_hold} + {right_hold[DATA_WIDTH-1], right_hold};

    always_comb begin
        case (MONO_SEL)
            0:       mono = left_hold;
            1:       mono = right_hold;
            default: mono = DATA_WIDTH'(avg_sum >> 1);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            audio_out    <= '0;
            audio_left   <= '0;
            audio_right  <= '0;
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (frame_done && enable) begin
                sample_valid <= 1'b1;
                audio_left   <= left_hold;
                audio_right  <= right_hold;
                audio_out    <= mono;
            end
            if (err_set)
                frame_err <= 1'b1;
            else if (err_clr)
                frame_err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_i2s_rx_frontend.sv
// Self-checking bench: drives I2S frames word by word and checks samples, latency and errors.
module tb_i2s_rx_frontend;
    logic        clk = 1'b0;
    logic        rst, i2s_bclk, i2s_lrck, i2s_sdata, enable, err_clr;
    logic [15:0] o2, o0, al, ar, al0, ar0;
    logic        v2, v0, fe2, fe0;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic [15:0] o0;
        logic [15:0] o2;
    } vec_t;

    vec_t tbl[6];
    vec_t expq[$];
    vec_t e;
    int   checks = 0, failures = 0;
    int   cyc = 0, word_end_cyc = 0;
    logic [15:0] last_l = '0, last_r = '0, last_o0 = '0, last_o2 = '0;

    i2s_rx_frontend #(.DATA_WIDTH(16), .SLOT_WIDTH(32), .MONO_SEL(2)) dut (
        .clk(clk), .rst(rst), .i2s_bclk(i2s_bclk), .i2s_lrck(i2s_lrck), .i2s_sdata(i2s_sdata),
        .enable(enable), .err_clr(err_clr), .audio_out(o2), .audio_left(al), .audio_right(ar),
        .sample_valid(v2), .frame_err(fe2));

    i2s_rx_frontend #(.DATA_WIDTH(16), .SLOT_WIDTH(32), .MONO_SEL(0)) dut_l (
        .clk(clk), .rst(rst), .i2s_bclk(i2s_bclk), .i2s_lrck(i2s_lrck), .i2s_sdata(i2s_sdata),
        .enable(enable), .err_clr(err_clr), .audio_out(o0), .audio_left(al0), .audio_right(ar0),
        .sample_valid(v0), .frame_err(fe0));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] avg_model(input logic [15:0] a, input logic [15:0] b);
        int s;
        s = int'($signed(a)) + int'($signed(b));
        return 16'(s >>> 1);
    endfunction

    function automatic vec_t mk(input logic [15:0] l, input logic [15:0] r);
        vec_t v;
        v.l = l; v.r = r; v.o0 = l; v.o2 = avg_model(l, r);
        return v;
    endfunction

    // Monitor: every strobe must match the next expected frame; between strobes outputs hold.
    always @(negedge clk) begin
        if (rst) begin
            last_l = '0; last_r = '0; last_o0 = '0; last_o2 = '0;
        end else if (v2 || v0) begin
            chk("valid_pair", {63'd0, v0}, {63'd0, v2});
            if (expq.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_valid actual=1 expected=0 at cyc %0d", cyc);
            end else begin
                e = expq.pop_front();
                chk("audio_left", 64'(al), 64'(e.l));
                chk("audio_right", 64'(ar), 64'(e.r));
                chk("audio_out_avg", 64'(o2), 64'(e.o2));
                chk("audio_out_left", 64'(o0), 64'(e.o0));
                chk("latency", 64'(cyc - word_end_cyc), 64'd4);
            end
            last_l = al; last_r = ar; last_o0 = o0; last_o2 = o2;
        end else begin
            chk("hold", {al, ar, o0, o2}, {last_l, last_r, last_o0, last_o2});
        end
    end

    // One BCLK period; lrck/sdata change with the falling edge. Called at a clk negedge.
    task automatic send_bit(input logic lr, input logic d, input logic mark);
        i2s_bclk = 1'b0; i2s_lrck = lr; i2s_sdata = d;
        repeat ($urandom_range(2, 4)) @(negedge clk);
        i2s_bclk = 1'b1;
        if (mark) word_end_cyc = cyc;
        repeat ($urandom_range(2, 4)) @(negedge clk);
    endtask

    // First event carries the previous slot's last bit, then nbits MSB-first, then padding.
    task automatic send_slot(input logic lr, input logic [15:0] w, input int nbits,
                             input int pad, input logic mark);
        send_bit(lr, 1'($urandom), 1'b0);
        for (int i = 0; i < nbits; i++)
            send_bit(lr, w[15-i], mark && (i == 15));
        for (int i = 0; i < pad; i++)
            send_bit(lr, 1'($urandom), 1'b0);
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int kl, input int kr);
        send_slot(1'b0, l, 16, kl - 17, 1'b0);
        send_slot(1'b1, r, 16, kr - 17, 1'b1);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        repeat (8) @(negedge clk);
        while (expq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL %s pending_valids actual=%0d expected=0", name, expq.size());
            expq.delete();
        end
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog cycles=%0d expected_finish_before_timeout", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{16'h1234, 16'hABCD, 16'h1234, 16'hDF00};
        tbl[1] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        tbl[2] = '{16'h8000, 16'hFFFF, 16'h8000, 16'hBFFF};
        tbl[3] = '{16'h0001, 16'hFFFE, 16'h0001, 16'hFFFF};
        tbl[4] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
        tbl[5] = '{16'h0003, 16'h0004, 16'h0003, 16'h0003};

        rst = 1'b1; i2s_bclk = 1'b0; i2s_lrck = 1'b0; i2s_sdata = 1'b0;
        enable = 1'b1; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {o2, al, ar, o0}, 64'd0);
        chk("reset_flags", {62'd0, v2, fe2}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Stream joins mid-right-slot: must stay silent and error-free.
        send_slot(1'b1, 16'h0F0F, 10, 0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            expq.push_back(tbl[i]);
            send_frame(tbl[i].l, tbl[i].r, 32, 32);
            drain("table_frame");
        end
        chk("no_err_after_midslot_start", {63'd0, fe2}, 64'd0);

        for (int i = 0; i < 20; i++) begin
            logic [15:0] l, r;
            l = 16'($urandom); r = 16'($urandom);
            expq.push_back(mk(l, r));
            send_frame(l, r, int'($urandom_range(17, 32)), int'($urandom_range(17, 32)));
        end
        drain("random_frames");
        chk("no_err_random", {63'd0, fe2}, 64'd0);

        // Left slot cut to 10 bits.
        send_slot(1'b0, 16'hAAAA, 10, 0, 1'b0);
        send_slot(1'b1, 16'h5555, 16, 15, 1'b1);
        drain("short_left");
        chk("short_word_err", {63'd0, fe2}, 64'd1);
        expq.push_back(mk(16'h0F00, 16'hF00F));
        send_frame(16'h0F00, 16'hF00F, 32, 32);
        drain("after_short");
        chk("err_sticky", {63'd0, fe2}, 64'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
        chk("err_clr", {63'd0, fe2}, 64'd0);

        // lrck static for 40+ BCLK periods.
        send_slot(1'b0, 16'h5A5A, 16, 24, 1'b0);
        send_slot(1'b1, 16'hA5A5, 16, 15, 1'b1);
        drain("static_lrck");
        chk("overflow_err", {63'd0, fe2}, 64'd1);
        expq.push_back(mk(16'hC001, 16'h3FFE));
        send_frame(16'hC001, 16'h3FFE, 32, 32);
        drain("resync_after_overflow");
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
        chk("err_clr2", {63'd0, fe2}, 64'd0);

        // enable dropped mid-right-word.
        expq.push_back(mk(16'h2468, 16'h1357));
        send_frame(16'h2468, 16'h1357, 32, 32);
        drain("pre_enable");
        send_slot(1'b0, 16'h1111, 16, 15, 1'b0);
        send_slot(1'b1, 16'h2222, 8, 0, 1'b0);
        enable = 1'b0;
        repeat (6) @(negedge clk);
        enable = 1'b1;
        send_slot(1'b1, 16'h2200, 8, 15, 1'b0);
        drain("enable_abort");
        chk("enable_hold_left", 64'(al), 64'h2468);
        chk("enable_no_err", {63'd0, fe2}, 64'd0);
        expq.push_back(mk(16'h8001, 16'h8001));
        send_frame(16'h8001, 16'h8001, 32, 32);
        drain("after_enable");

        // Reset mid-word clears outputs immediately.
        send_slot(1'b0, 16'hBEEF, 8, 0, 1'b0);
        #2 rst = 1'b1;
        #1 chk("rst_async_outputs", {o2, al, ar, o0}, 64'd0);
        chk("rst_async_flags", {62'd0, v2, fe2}, 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_slot(1'b0, 16'h1111, 16, 15, 1'b0);
        send_slot(1'b1, 16'h2222, 16, 15, 1'b1);
        drain("post_rst_partial");
        expq.push_back(mk(16'h7FFF, 16'h8000));
        send_frame(16'h7FFF, 16'h8000, 32, 32);
        drain("post_rst_frame");
        chk("post_rst_no_err", {63'd0, fe2}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
